// File: rtl/soc_system_pio_pkg.sv
// Shared constants and helpers for the PIO input-conditioning blocks.
//   SYNC_STAGES             : depth of the clock-domain synchroniser
//   DEFAULT_DEBOUNCE_CYCLES : 1 ms at 50 MHz
//   clog2 / cnt_width       : elaboration-time counter sizing
package soc_system_pio_pkg;

   localparam int unsigned SYNC_STAGES             = 2;
   localparam int unsigned DEFAULT_DEBOUNCE_CYCLES = 50000;

   // Ceiling log2; clog2(0) = clog2(1) = 0.
   function automatic int unsigned clog2(input int unsigned value);
      int unsigned result;
      result = 0;
      for (int unsigned i = 0; i < 32; i++) begin
         if ((64'd1 << i) < 64'(value)) begin
            result = i + 1;
         end
      end
      return result;
   endfunction

   // Counter width for a debounce run, never narrower than one bit.
   function automatic int unsigned cnt_width(input int unsigned cycles);
      int unsigned w;
      w = clog2(cycles);
      return (w < 1) ? 1 : w;
   endfunction

endpackage : soc_system_pio_pkg

// File: rtl/soc_system_debounce_bit.sv
// One switch bit: two-flop synchroniser, saturating debounce counter,
// debounced level flop and one-cycle change pulse flop.
//   clk       : system clock
//   reset_n   : asynchronous active-low reset
//   sw_raw    : raw, asynchronous switch pin
//   sw_stable : debounced level (registered)
//   sw_change : one-cycle pulse when sw_stable toggles (registered)
module soc_system_debounce_bit
   import soc_system_pio_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
   parameter logic        RESET_BIT       = 1'b0
) (
   input  logic clk,
   input  logic reset_n,
   input  logic sw_raw,
   output logic sw_stable,
   output logic sw_change
);

   localparam int unsigned    CW       = cnt_width(DEBOUNCE_CYCLES);
   localparam logic [CW-1:0]  CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

   logic [SYNC_STAGES-1:0] sync_q;
   logic [CW-1:0]          cnt_q;
   logic [CW-1:0]          cnt_d;
   logic                   stable_d;
   logic                   change_d;
   logic                   sync_out;

   assign sync_out = sync_q[SYNC_STAGES-1];

   // Synchroniser: pure flop chain, nothing between stages.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync_q <= {SYNC_STAGES{RESET_BIT}};
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], sw_raw};
      end
   end

   // Debounce next-state: any cycle back at the stable level clears the run.
   always_comb begin
      cnt_d    = '0;
      stable_d = sw_stable;
      change_d = 1'b0;
      if (sync_out != sw_stable) begin
         if (cnt_q == CNT_LAST) begin
            stable_d = sync_out;
            change_d = 1'b1;
         end else begin
            cnt_d = cnt_q + CW'(1);
         end
      end
   end

   // Debounce state register.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt_q     <= '0;
         sw_stable <= RESET_BIT;
         sw_change <= 1'b0;
      end else begin
         cnt_q     <= cnt_d;
         sw_stable <= stable_d;
         sw_change <= change_d;
      end
   end

endmodule : soc_system_debounce_bit

// File: rtl/soc_system_dipsw_debounce.sv
// DIP-switch conditioning ahead of the PIO in_port: per-bit synchronise and
// debounce, plus per-bit change pulses and their OR for future IRQ logic.
//   clk        : system clock
//   reset_n    : asynchronous active-low reset
//   sw_raw     : raw switch pins (WIDTH)
//   sw_stable  : debounced levels (WIDTH, registered)
//   sw_change  : one-cycle toggle pulses (WIDTH, registered)
//   any_change : OR of sw_change (combinational from registered pulses)
module soc_system_dipsw_debounce
   import soc_system_pio_pkg::*;
#(
   parameter int unsigned      WIDTH           = 4,
   parameter int unsigned      DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
   parameter logic [WIDTH-1:0] RESET_VALUE     = '0
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [WIDTH-1:0] sw_raw,
   output logic [WIDTH-1:0] sw_stable,
   output logic [WIDTH-1:0] sw_change,
   output logic             any_change
);

   // Bits are fully independent; one conditioner per pin.
   for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      soc_system_debounce_bit #(
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
         .RESET_BIT       (RESET_VALUE[i])
      ) u_bit (
         .clk       (clk),
         .reset_n   (reset_n),
         .sw_raw    (sw_raw[i]),
         .sw_stable (sw_stable[i]),
         .sw_change (sw_change[i])
      );
   end

   assign any_change = |sw_change;

endmodule : soc_system_dipsw_debounce

// File: tb/tb_soc_system_dipsw_debounce.sv
// Bench for soc_system_dipsw_debounce: two instances (DEBOUNCE_CYCLES 4 and 1)
// share the same stimulus; a window-based model checks every cycle and
// directed literal checks pin the model's timing.
module tb_soc_system_dipsw_debounce;

   localparam int unsigned W = 4;

   logic         clk;
   logic         reset_n;
   logic [W-1:0] sw_raw;
   logic [W-1:0] a_stable, a_change;
   logic         a_any;
   logic [W-1:0] b_stable, b_change;
   logic         b_any;

   int checks = 0;
   int errors = 0;

   soc_system_dipsw_debounce #(
      .WIDTH (W), .DEBOUNCE_CYCLES (4), .RESET_VALUE (4'h0)
   ) dut_a (
      .clk (clk), .reset_n (reset_n), .sw_raw (sw_raw),
      .sw_stable (a_stable), .sw_change (a_change), .any_change (a_any)
   );

   soc_system_dipsw_debounce #(
      .WIDTH (W), .DEBOUNCE_CYCLES (1), .RESET_VALUE (4'h0)
   ) dut_b (
      .clk (clk), .reset_n (reset_n), .sw_raw (sw_raw),
      .sw_stable (b_stable), .sw_change (b_change), .any_change (b_any)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- model ----------------
   // hist[k] is the raw value sampled at post-reset edge k. A bit updates at
   // edge k when the synchronised value seen at each of the last dc edges
   // differed from the stable level, and all of those edges fall after the
   // bit's previous update (or after reset).
   logic [W-1:0] hist [0:4095];
   int           k_edge;
   logic [W-1:0] m_stable [2];
   logic [W-1:0] m_change [2];
   int           m_last   [2][W];
   int           a_pulses [W];

   function automatic logic [W-1:0] sync_seen(input int m);
      return (m >= 2) ? hist[m-2] : 4'h0;
   endfunction

   always @(posedge clk) begin
      if (!reset_n) begin
         k_edge = 0;
         for (int d = 0; d < 2; d++) begin
            m_stable[d] = '0;
            m_change[d] = '0;
            for (int i = 0; i < W; i++) m_last[d][i] = -1;
         end
      end else begin
         hist[k_edge] = sw_raw;
         for (int d = 0; d < 2; d++) begin
            int dc;
            logic [W-1:0] nxt_stable;
            logic [W-1:0] seen;
            dc = (d == 0) ? 4 : 1;
            nxt_stable  = m_stable[d];
            m_change[d] = '0;
            for (int i = 0; i < W; i++) begin
               logic upd;
               upd = (k_edge - m_last[d][i] >= dc);
               for (int j = 0; j < dc; j++) begin
                  seen = sync_seen(k_edge - j);
                  if (seen[i] == m_stable[d][i]) upd = 1'b0;
               end
               if (upd) begin
                  nxt_stable[i]  = ~m_stable[d][i];
                  m_change[d][i] = 1'b1;
                  m_last[d][i]   = k_edge;
               end
            end
            m_stable[d] = nxt_stable;
         end
         if (k_edge < 4095) k_edge++;
      end
      #1;
      check("a_stable", a_stable, m_stable[0]);
      check("a_change", a_change, m_change[0]);
      check("a_any", {3'b0, a_any}, {3'b0, |m_change[0]});
      check("b_stable", b_stable, m_stable[1]);
      check("b_change", b_change, m_change[1]);
      check("b_any", {3'b0, b_any}, {3'b0, |m_change[1]});
      for (int i = 0; i < W; i++) if (a_change[i]) a_pulses[i]++;
   end

   // ---------------- stimulus ----------------
   task automatic set_raw(input logic [W-1:0] v);
      @(negedge clk);
      sw_raw = v;
   endtask

   task automatic wait_edges(input int n);
      repeat (n) @(posedge clk);
      #2;
   endtask

   int p0, p2;

   initial begin
      for (int i = 0; i < W; i++) a_pulses[i] = 0;
      reset_n = 1'b0;
      sw_raw  = 4'hF;

      // Reset with all switches on, then release.
      repeat (3) @(negedge clk);
      check("rst_a_stable", a_stable, 4'h0);
      check("rst_a_change", a_change, 4'h0);
      check("rst_b_stable", b_stable, 4'h0);
      reset_n = 1'b1;
      wait_edges(5);
      check("rst_a_pre", a_stable, 4'h0);
      wait_edges(1);
      check("rst_a_post", a_stable, 4'hF);
      check("rst_a_chg", a_change, 4'hF);
      check("rst_a_any", {3'b0, a_any}, 4'h1);
      wait_edges(1);
      check("rst_a_chg_end", a_change, 4'h0);

      // Clean step 0 -> 5.
      set_raw(4'h0);
      wait_edges(12);
      set_raw(4'h5);
      wait_edges(5);
      check("step_pre", a_stable, 4'h0);
      wait_edges(1);
      check("step_post", a_stable, 4'h5);
      check("step_chg", a_change, 4'h5);
      wait_edges(1);
      check("step_chg_end", a_change, 4'h0);

      // Bounce on bit 0: 1,0,1 one-cycle each, then hold 1.
      set_raw(4'h0);
      wait_edges(12);
      p0 = a_pulses[0];
      set_raw(4'h1);
      set_raw(4'h0);
      set_raw(4'h1);
      wait_edges(5);
      check("bounce_pre", a_stable, 4'h0);
      wait_edges(1);
      check("bounce_post", a_stable, 4'h1);
      wait_edges(4);
      check("bounce_pulses", 4'(a_pulses[0] - p0), 4'h1);

      // Glitch on bit 2 shorter than the debounce window.
      p2 = a_pulses[2];
      set_raw(4'h5);
      repeat (2) @(negedge clk);
      set_raw(4'h1);
      wait_edges(10);
      check("glitch_stable", a_stable, 4'h1);
      check("glitch_pulses", 4'(a_pulses[2] - p2), 4'h0);

      // Reset part way through bit 1's count.
      set_raw(4'h3);
      repeat (5) @(negedge clk);
      reset_n = 1'b0;
      @(negedge clk);
      reset_n = 1'b1;
      wait_edges(5);
      check("midrst_pre", a_stable, 4'h0);
      wait_edges(1);
      check("midrst_post", a_stable, 4'h3);
      check("midrst_chg", a_change, 4'h3);

      // Opposite edges on all bits, DEBOUNCE_CYCLES=4.
      set_raw(4'hA);
      wait_edges(12);
      check("opp_start", a_stable, 4'hA);
      set_raw(4'h5);
      wait_edges(5);
      check("opp_pre", a_stable, 4'hA);
      wait_edges(1);
      check("opp_post", a_stable, 4'h5);
      check("opp_chg", a_change, 4'hF);
      check("opp_any", {3'b0, a_any}, 4'h1);
      wait_edges(1);
      check("opp_any_end", {3'b0, a_any}, 4'h0);

      // Opposite edges, DEBOUNCE_CYCLES=1: update on the third edge.
      set_raw(4'hA);
      wait_edges(12);
      set_raw(4'h5);
      wait_edges(2);
      check("b_opp_pre", b_stable, 4'hA);
      wait_edges(1);
      check("b_opp_post", b_stable, 4'h5);
      check("b_opp_chg", b_change, 4'hF);
      check("b_opp_any", {3'b0, b_any}, 4'h1);
      wait_edges(1);
      check("b_opp_chg_end", b_change, 4'h0);

      wait_edges(3);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule : tb_soc_system_dipsw_debounce
